// File: rtl/ysyx_25060170_idu_stage_if.sv
// Handshake and decoded-instruction bus of the decode stage.
// The stage uses the slave view; the IFU/EXU side uses the master view.
interface ysyx_25060170_idu_stage_if #(
   parameter int unsigned XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_inst;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [3:0]      out_class;
   logic [2:0]      out_funct3;
   logic            out_alt;
   logic            out_mext;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic            out_rs1_ena;
   logic            out_rs2_ena;
   logic [1:0]      out_wb_ctl;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   modport master (
      output in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_class, out_funct3, out_alt, out_mext,
             out_rd, out_rs1, out_rs2, out_rs1_ena, out_rs2_ena, out_wb_ctl,
             out_imm, out_illegal
   );

   modport slave (
      input  in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_class, out_funct3, out_alt, out_mext,
             out_rd, out_rs1, out_rs2, out_rs1_ena, out_rs2_ena, out_wb_ctl,
             out_imm, out_illegal
   );
endinterface

// File: rtl/ysyx_25060170_idu_stage.sv
// Instruction-decode stage: small {pc, inst} FIFO from the IFU, decode of the
// FIFO head, and a registered valid/ready output towards the EXU.
module ysyx_25060170_idu_stage #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter bit          EN_M       = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   ysyx_25060170_idu_stage_if.slave bus,
   output logic [31:0]              dec_cnt
);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam bit          IS_RV32 = (XLEN == 32);

   typedef enum logic [3:0] {
      CLS_ILL = 4'd0, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
      CLS_STORE, CLS_OPIMM, CLS_OP, CLS_OPIMM32, CLS_OP32, CLS_SYSTEM
   } cls_e;

   localparam logic [1:0] WB_NONE = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_REG  = 2'b10;

   typedef struct packed {
      cls_e            cls;
      logic [2:0]      funct3;
      logic            alt;
      logic            mext;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic            rs1_ena;
      logic            rs2_ena;
      logic [1:0]      wb_ctl;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } dec_t;

   logic [XLEN-1:0]  fifo_pc   [FIFO_DEPTH];
   logic [31:0]      fifo_inst [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             in_ready_q, out_valid_q, push, pop;
   logic [XLEN-1:0]  out_pc_q;
   dec_t             dec, out_q;

   logic [31:0]      head;
   logic [4:0]       opc;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic             f7_ok, ill;
   logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

   // FIFO control; a flush wins over both push and pop
   always_comb begin
      push    = bus.in_valid && in_ready_q && !flush;
      pop     = (cnt != '0) && (!out_valid_q || bus.out_ready) && !flush;
      cnt_nxt = cnt;
      if (flush)             cnt_nxt = '0;
      else if (push && !pop) cnt_nxt = cnt + CNT_W'(1);
      else if (pop && !push) cnt_nxt = cnt - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         in_ready_q <= 1'b1;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
         cnt        <= cnt_nxt;
         in_ready_q <= (cnt_nxt != CNT_W'(FIFO_DEPTH));
      end
   end

   // Payload storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= bus.in_pc;
         fifo_inst[wr_ptr] <= bus.in_inst;
      end
   end

   // Decode of the FIFO head
   always_comb begin
      head  = fifo_inst[rd_ptr];
      opc   = head[6:2];
      f3    = head[14:12];
      f7    = head[31:25];
      f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000) || (f7 == 7'b0000001);
      imm_i = {{(XLEN-12){head[31]}}, head[31:20]};
      imm_s = {{(XLEN-12){head[31]}}, head[31:25], head[11:7]};
      imm_b = {{(XLEN-12){head[31]}}, head[7], head[30:25], head[11:8], 1'b0};
      imm_u = {{(XLEN-31){head[31]}}, head[30:12], 12'b0};
      imm_j = {{(XLEN-20){head[31]}}, head[19:12], head[20], head[30:21], 1'b0};
      ill   = 1'b0;
      dec        = '0;
      dec.funct3 = f3;
      dec.alt    = head[30];
      dec.rd     = head[11:7];
      dec.rs1    = head[19:15];
      dec.rs2    = head[24:20];
      case (opc)
         5'b01101: begin dec.cls = CLS_LUI;   dec.wb_ctl = WB_REG; dec.imm = imm_u; end
         5'b00101: begin dec.cls = CLS_AUIPC; dec.wb_ctl = WB_REG; dec.imm = imm_u; end
         5'b11011: begin dec.cls = CLS_JAL;   dec.wb_ctl = WB_REG; dec.imm = imm_j; end
         5'b11001: begin
            dec.cls = CLS_JALR; dec.wb_ctl = WB_REG; dec.rs1_ena = 1'b1; dec.imm = imm_i;
         end
         5'b11000: begin
            dec.cls = CLS_BRANCH; dec.rs1_ena = 1'b1; dec.rs2_ena = 1'b1; dec.imm = imm_b;
         end
         5'b00000: begin
            dec.cls = CLS_LOAD; dec.wb_ctl = WB_LOAD; dec.rs1_ena = 1'b1; dec.imm = imm_i;
            ill = (f3 == 3'b111) || (IS_RV32 && ((f3 == 3'b011) || (f3 == 3'b110)));
         end
         5'b01000: begin
            dec.cls = CLS_STORE; dec.rs1_ena = 1'b1; dec.rs2_ena = 1'b1; dec.imm = imm_s;
            ill = f3[2] || (IS_RV32 && (f3 == 3'b011));
         end
         5'b00100: begin
            dec.cls = CLS_OPIMM; dec.wb_ctl = WB_REG; dec.rs1_ena = 1'b1; dec.imm = imm_i;
         end
         5'b00110: begin
            dec.cls = CLS_OPIMM32; dec.wb_ctl = WB_REG; dec.rs1_ena = 1'b1; dec.imm = imm_i;
            ill = IS_RV32;
         end
         5'b01100, 5'b01110: begin
            dec.cls     = (opc[1]) ? CLS_OP32 : CLS_OP;
            dec.wb_ctl  = WB_REG;
            dec.rs1_ena = 1'b1;
            dec.rs2_ena = 1'b1;
            dec.mext    = (f7 == 7'b0000001);
            ill = !f7_ok || (dec.mext && !EN_M) || (opc[1] && IS_RV32);
         end
         5'b11100: begin dec.cls = CLS_SYSTEM; dec.wb_ctl = WB_REG; dec.imm = imm_i; end
         default:  ill = 1'b1;
      endcase
      if (head[1:0] != 2'b11) ill = 1'b1;
      // Illegal instructions still flow to the EXU, with no side effects requested
      if (ill) begin
         dec.cls     = CLS_ILL;
         dec.wb_ctl  = WB_NONE;
         dec.rs1_ena = 1'b0;
         dec.rs2_ena = 1'b0;
         dec.mext    = 1'b0;
         dec.imm     = '0;
      end
      dec.illegal = ill;
   end

   // Output register and decode counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_q       <= '0;
         dec_cnt     <= '0;
      end else begin
         if (out_valid_q && bus.out_ready) dec_cnt <= dec_cnt + 32'd1;
         if (flush) begin
            out_valid_q <= 1'b0;
         end else if (pop) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= fifo_pc[rd_ptr];
            out_q       <= dec;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_pc      = out_pc_q;
   assign bus.out_class   = out_q.cls;
   assign bus.out_funct3  = out_q.funct3;
   assign bus.out_alt     = out_q.alt;
   assign bus.out_mext    = out_q.mext;
   assign bus.out_rd      = out_q.rd;
   assign bus.out_rs1     = out_q.rs1;
   assign bus.out_rs2     = out_q.rs2;
   assign bus.out_rs1_ena = out_q.rs1_ena;
   assign bus.out_rs2_ena = out_q.rs2_ena;
   assign bus.out_wb_ctl  = out_q.wb_ctl;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_illegal = out_q.illegal;
endmodule

// File: doc/ysyx_25060170_idu_stage.md
Name: ysyx_25060170_idu_stage

Overview:
Registered, parametrised instruction-decode stage between IFU and EXU.
- Buffers fetched {pc, inst} pairs in a small FIFO and decodes the FIFO head.
- Presents decoded fields in an output register with valid/ready handshakes on both sides.
- Supports RV32 or RV64, optional M extension, illegal-instruction flagging, pipeline flush and a decode counter.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
FIFO_DEPTH, 2, input buffer entries; power of two, at least 2.
EN_M, 1, 1 = M-extension opcodes legal; 0 = M opcodes flagged illegal.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous active-low reset.
flush  in  1  synchronous flush request from EXU/redirect logic.
in_valid  in  1  IFU has an instruction.
in_ready  out  1  stage can accept an instruction.
in_pc  in  XLEN  instruction PC.
in_inst  in  32  instruction word.
out_valid  out  1  decoded instruction available.
out_ready  in  1  EXU accepts the decoded instruction.
out_pc  out  XLEN  PC of the decoded instruction.
out_class  out  4  opcode class: 0 ILL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OPIMM, 9 OP, 10 OPIMM32, 11 OP32, 12 SYSTEM.
out_funct3  out  3  inst[14:12].
out_alt  out  1  inst[30]; selects sub/sra/srai.
out_mext  out  1  OP/OP32 with funct7 = 0000001.
out_rd, out_rs1, out_rs2  out  5 each  register indices.
out_rs1_ena, out_rs2_ena  out  1 each  source register read enables.
out_wb_ctl  out  2  write-back select: 00 none, 01 load, 10 register.
out_imm  out  XLEN  sign-extended immediate.
out_illegal  out  1  illegal instruction flag.
dec_cnt  out  32  count of decoded instructions handed to EXU.

Behaviour:
- Reset (rst = 0, asynchronous):
  - FIFO empty; out_valid = 0; dec_cnt = 0.
  - All out_* data outputs = 0.
  - in_ready = 1 once rst deasserts.
- Reset mid-operation discards all buffered and output contents.
- FIFO:
  - in_ready = !full.
  - Push when in_valid && in_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter ranges 0 to FIFO_DEPTH.
  - Simultaneous push and pop at full is not permitted, because in_ready is already low.
- Output register:
  - Loads from the FIFO head when the FIFO is non-empty and (!out_valid || out_ready). The load pops the FIFO.
  - out_valid clears when out_ready is high and nothing is loaded that cycle.
  - Outputs hold stable while out_valid && !out_ready.
- Latency and throughput:
  - An instruction pushed at edge T is visible with out_valid = 1 after edge T+1.
  - Sustained throughput is 1 per cycle.
  - There is no combinational path from in_* to out_*.
- dec_cnt increments by 1 on each out_valid && out_ready. Wraps at 2^32.
- Flush:
  - Next edge empties the FIFO and clears out_valid.
  - A push in the same cycle is dropped.
  - A flush takes priority over the handshake: a same-cycle out handshake still counts in dec_cnt.
- Decode:
  - Class comes from inst[6:2] and requires inst[1:0] = 11.
  - rs1_ena is set for JALR, BRANCH, LOAD, STORE, OPIMM, OPIMM32, OP and OP32.
  - rs2_ena is set for BRANCH, STORE, OP and OP32.
  - wb_ctl = 01 for LOAD.
  - wb_ctl = 10 for LUI, AUIPC, JAL, JALR, OPIMM, OPIMM32, OP, OP32 and SYSTEM.
  - wb_ctl = 00 otherwise.
- Immediates, all sign-extended to XLEN:
  - I-type for JALR, LOAD, OPIMM, OPIMM32 and SYSTEM.
  - S-type for STORE.
  - B-type for BRANCH, with bit 0 = 0.
  - U-type for LUI and AUIPC: inst[31:12] followed by 12 zero bits.
  - J-type for JAL, with bit 0 = 0.
  - 0 for OP, OP32 and ILL.
- Illegal when any of the following holds:
  - inst[1:0] != 11, or unknown opcode.
  - OP funct7 not in {0000000, 0100000, 0000001}.
  - M-extension op with EN_M = 0.
  - XLEN = 32 and any of: OPIMM32, OP32, LOAD funct3 011/110, STORE funct3 011.
  - LOAD funct3 = 111, or STORE funct3 >= 100.
- On illegal: out_class = 0, wb_ctl = 00, rs enables = 0, out_imm = 0, out_illegal = 1. The instruction is still delivered with its out_pc.

Test Plan:
1. Reset, then push pc = 0x80000000, inst = 0x00500093 (addi x1,x0,5) with out_ready = 1 -> two edges later: out_valid = 1, class = 8, rd = 1, rs1 = 0, imm = 5, wb_ctl = 10, rs1_ena = 1, rs2_ena = 0; dec_cnt = 1 after the handshake.
2. Hold out_ready = 0 and push 4 instructions with FIFO_DEPTH = 2 -> in_ready drops after the 3rd accept (2 in FIFO, 1 in output register); outputs hold stable. Release out_ready -> all 3 delivered in order on consecutive cycles.
3. Push 0xFE000EE3 (beq x0,x0,-4) -> class = 5, imm = 0xFFFF_FFFF_FFFF_FFFC, rs2_ena = 1, wb_ctl = 00.
4. EN_M = 0, push 0x022081B3 (mul x3,x1,x2) -> illegal = 1, class = 0. With EN_M = 1 -> class = 9, mext = 1, rd = 3.
5. XLEN = 32, push 0x00013083 (ld x1,0(x2)) -> illegal = 1. Push 0x00012083 (lw) -> class = 6, wb_ctl = 01.
6. With 2 entries buffered and out_valid = 1, assert flush together with in_valid -> next cycle: out_valid = 0, FIFO empty, pushed instruction dropped. Then assert rst low mid-stream -> all outputs 0 immediately.
